// File: rtl/sar_pkg.sv
// Shared definitions for the SAR ADC controller: FSM state values, default
// resolution and the trial-code helper used by the bit register.
package sar_pkg;

  localparam int DEFAULT_N_BITS = 10;

  typedef logic [31:0] sar_state_t;

  localparam sar_state_t IDLE      = 32'd0;
  localparam sar_state_t SAMPLE    = 32'd1;
  localparam sar_state_t HOLD_WAIT = 32'd2;
  localparam sar_state_t CONVERT   = 32'd3;
  localparam sar_state_t DONE      = 32'd4;

  // Next trial = bits already decided, plus a tentative one at bit_pos.
  function automatic logic [31:0] sar_trial(input logic [31:0] partial, input int bit_pos);
    return partial | (32'd1 << bit_pos);
  endfunction

endpackage

// File: rtl/sar_controller_if.sv
// Signal bundle between the SAR controller (master) and its environment:
// conversion handshake, sample/hold control, held voltage and DAC trial code.
interface sar_controller_if #(parameter int N_BITS = sar_pkg::DEFAULT_N_BITS);

  logic              start;
  logic              sh_control_digital;
  logic [N_BITS-1:0] held_voltage_real;
  logic [N_BITS-1:0] dac_code;
  logic [N_BITS-1:0] code_out;
  logic              code_valid;
  logic              busy;

  modport master (
    input  start, held_voltage_real,
    output sh_control_digital, dac_code, code_out, code_valid, busy
  );

  modport slave (
    output start, held_voltage_real,
    input  sh_control_digital, dac_code, code_out, code_valid, busy
  );

endinterface

// File: rtl/sar_bit_register.sv
// Successive-approximation register: holds the partial result, the bit under
// test and the current trial code; load starts a search, decide resolves one bit.
module sar_bit_register
  import sar_pkg::*;
#(
  parameter int N_BITS = DEFAULT_N_BITS,
  localparam int BIT_W = (N_BITS > 1) ? $clog2(N_BITS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              decide,
  input  logic [N_BITS-1:0] held,
  output logic [N_BITS-1:0] result,
  output logic [BIT_W-1:0]  bit_idx,
  output logic [N_BITS-1:0] trial
);

  localparam logic [BIT_W-1:0] TOP_BIT = BIT_W'(N_BITS - 1);

  logic [N_BITS-1:0] result_q, result_d;
  logic [BIT_W-1:0]  bit_idx_q, bit_idx_d;
  logic [N_BITS-1:0] trial_q, trial_d;
  logic [N_BITS-1:0] decided;

  always_comb begin
    result_d  = result_q;
    bit_idx_d = bit_idx_q;
    trial_d   = trial_q;
    // Ideal comparator: the bit stays set when the held level reaches the trial.
    decided          = result_q;
    decided[bit_idx_q] = (held >= trial_q);

    if (load) begin
      result_d  = '0;
      bit_idx_d = TOP_BIT;
      trial_d   = N_BITS'(sar_trial(32'd0, N_BITS - 1));
    end else if (decide) begin
      result_d = decided;
      if (bit_idx_q != '0) begin
        bit_idx_d = bit_idx_q - 1'b1;
        trial_d   = N_BITS'(sar_trial(32'(decided), int'(bit_idx_q) - 1));
      end else begin
        trial_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result_q  <= '0;
      bit_idx_q <= '0;
      trial_q   <= '0;
    end else begin
      result_q  <= result_d;
      bit_idx_q <= bit_idx_d;
      trial_q   <= trial_d;
    end
  end

  assign result  = result_q;
  assign bit_idx = bit_idx_q;
  assign trial   = trial_q;

endmodule

// File: rtl/sar_controller.sv
// SAR ADC controller: track/hold sequencing, binary search and result hand-off.
// Define SAR_CONTINUOUS_EN to restart sampling straight after every conversion.
module sar_controller
  import sar_pkg::*;
#(
  parameter int N_BITS        = DEFAULT_N_BITS,
  parameter int SAMPLE_CYCLES = 4,
  parameter int SETTLE_CYCLES = 1,
  localparam int BIT_W = (N_BITS > 1) ? $clog2(N_BITS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  sar_controller_if.master bus
);

  sar_state_t        state_q, state_d;
  logic [31:0]       cnt_q, cnt_d;
  logic              sh_control_q, sh_control_d;
  logic              busy_q, busy_d;
  logic [N_BITS-1:0] code_out_q, code_out_d;
  logic              code_valid_q, code_valid_d;

  logic              load;
  logic              decide;
  logic [N_BITS-1:0] result;
  logic [BIT_W-1:0]  bit_idx;
  logic [N_BITS-1:0] trial;

  sar_bit_register #(.N_BITS(N_BITS)) u_bits (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .decide (decide),
    .held   (bus.held_voltage_real),
    .result (result),
    .bit_idx(bit_idx),
    .trial  (trial)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    decide  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SAMPLE;
          cnt_d   = '0;
        end
      end
      SAMPLE: begin
        if (cnt_q == 32'(SAMPLE_CYCLES - 1)) begin
          state_d = HOLD_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      HOLD_WAIT: begin
        // The sample/hold output only becomes valid one cycle after it captures.
        state_d = CONVERT;
        load    = 1'b1;
        cnt_d   = '0;
      end
      CONVERT: begin
        if (cnt_q == 32'(SETTLE_CYCLES - 1)) begin
          decide = 1'b1;
          cnt_d  = '0;
          if (bit_idx == '0) state_d = DONE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      DONE: begin
        cnt_d = '0;
`ifdef SAR_CONTINUOUS_EN
        state_d = SAMPLE;
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase

    sh_control_d = (state_d == HOLD_WAIT) || (state_d == CONVERT);
    busy_d       = (state_d != IDLE);
    code_valid_d = (state_q == DONE);
    code_out_d   = (state_q == DONE) ? result : code_out_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      sh_control_q <= 1'b0;
      busy_q       <= 1'b0;
      code_out_q   <= '0;
      code_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sh_control_q <= sh_control_d;
      busy_q       <= busy_d;
      code_out_q   <= code_out_d;
      code_valid_q <= code_valid_d;
    end
  end

  assign bus.sh_control_digital = sh_control_q;
  assign bus.dac_code           = trial;
  assign bus.code_out           = code_out_q;
  assign bus.code_valid         = code_valid_q;
  assign bus.busy               = busy_q;

endmodule

// File: tb/tb_sar_controller.sv
// Directed bench for sar_controller: two instances (default timing and
// SAMPLE_CYCLES=2/SETTLE_CYCLES=3) share start and input voltage, each with an ideal S&H.
module tb_sar_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [9:0] vin = '0;
  logic [9:0] held1, held2;
  logic       ctrl1_prev, ctrl2_prev;

  int vectors = 0;
  int misses  = 0;

  always #5 clk = ~clk;

  sar_controller_if #(.N_BITS(10)) bus1 ();
  sar_controller_if #(.N_BITS(10)) bus2 ();

  assign bus1.start             = start;
  assign bus2.start             = start;
  assign bus1.held_voltage_real = held1;
  assign bus2.held_voltage_real = held2;

  sar_controller #(.N_BITS(10), .SAMPLE_CYCLES(4), .SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  sar_controller #(.N_BITS(10), .SAMPLE_CYCLES(2), .SETTLE_CYCLES(3)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2)
  );

  // Ideal sample/hold: tracks while control is low, captures on the first high edge.
  always @(posedge clk) begin
    if (reset) begin
      held1 <= '0; held2 <= '0; ctrl1_prev <= 1'b0; ctrl2_prev <= 1'b0;
    end else begin
      if (!bus1.sh_control_digital || !ctrl1_prev) held1 <= vin;
      if (!bus2.sh_control_digital || !ctrl2_prev) held2 <= vin;
      ctrl1_prev <= bus1.sh_control_digital;
      ctrl2_prev <= bus2.sh_control_digital;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      misses++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Pulses start and follows both instances until each has produced a code.
  task automatic applyStimulus(
    input  logic [9:0] v,
    input  int         restart_at,
    input  int         change_at,
    input  logic [9:0] change_val,
    output int         lat1,
    output int         lat2,
    output logic [9:0] code1,
    output logic [9:0] code2,
    output logic [9:0] dac5,
    output logic [9:0] dac6,
    output int         ctrl_high,
    output int         valids1
  );
    int cyc;
    vin = v;
    lat1 = -1; lat2 = -1; code1 = '0; code2 = '0; dac5 = '0; dac6 = '0;
    ctrl_high = 0; valids1 = 0; cyc = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while ((lat1 < 0 || lat2 < 0) && cyc < 200) begin
      @(negedge clk);
      cyc++;
      start = (cyc == restart_at);
      if (cyc == change_at) vin = change_val;
      if (bus1.sh_control_digital) ctrl_high++;
      if (cyc == 5) dac5 = bus1.dac_code;
      if (cyc == 6) dac6 = bus1.dac_code;
      if (bus1.code_valid) begin
        valids1++;
        if (lat1 < 0) begin lat1 = cyc; code1 = bus1.code_out; end
      end
      if (bus2.code_valid && lat2 < 0) begin lat2 = cyc; code2 = bus2.code_out; end
    end
    start = 1'b0;
  endtask

  int         lat1, lat2, ctrl_high, valids1, extra;
  logic [9:0] code1, code2, dac5, dac6;

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_sh_control", 32'(bus1.sh_control_digital), 32'd0);
    checkOutput("reset_dac_code", 32'(bus1.dac_code), 32'd0);
    checkOutput("reset_code_out", 32'(bus1.code_out), 32'd0);
    checkOutput("reset_code_valid", 32'(bus1.code_valid), 32'd0);
    checkOutput("reset_busy", 32'(bus1.busy) + 32'(bus2.busy), 32'd0);

`ifdef SAR_CONTINUOUS_EN
    begin
      int cyc = 0;
      int t1[3];
      int t2[3];
      int n1 = 0, n2 = 0;
      vin = 10'd645;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      while ((n1 < 3 || n2 < 3) && cyc < 300) begin
        @(negedge clk);
        cyc++;
        if (bus1.code_valid && n1 < 3) begin
          t1[n1] = cyc; n1++;
          checkOutput("cont_code1", 32'(bus1.code_out), 32'd645);
        end
        if (bus2.code_valid && n2 < 3) begin
          t2[n2] = cyc; n2++;
          checkOutput("cont_code2", 32'(bus2.code_out), 32'd645);
        end
      end
      checkOutput("cont_count1", 32'(n1), 32'd3);
      checkOutput("cont_count2", 32'(n2), 32'd3);
      checkOutput("cont_first1", 32'(t1[0]), 32'd16);
      checkOutput("cont_period1", 32'(t1[2] - t1[1]), 32'd16);
      checkOutput("cont_first2", 32'(t2[0]), 32'd34);
      checkOutput("cont_period2", 32'(t2[1] - t2[0]), 32'd34);
      checkOutput("cont_busy", 32'(bus1.busy) + 32'(bus2.busy), 32'd2);
    end
`else
    applyStimulus(10'd512, -1, -1, '0, lat1, lat2, code1, code2, dac5, dac6, ctrl_high, valids1);
    checkOutput("mid_latency", 32'(lat1), 32'd16);
    checkOutput("mid_code", 32'(code1), 32'd512);
    checkOutput("mid_trial0", 32'(dac5), 32'd512);
    checkOutput("mid_trial1", 32'(dac6), 32'd768);
    checkOutput("mid_ctrl_high", 32'(ctrl_high), 32'd11);
    checkOutput("settle_latency", 32'(lat2), 32'd34);
    checkOutput("settle_code_512", 32'(code2), 32'd512);

    applyStimulus(10'd0, -1, -1, '0, lat1, lat2, code1, code2, dac5, dac6, ctrl_high, valids1);
    checkOutput("zero_code", 32'(code1), 32'd0);
    checkOutput("zero_code_settle", 32'(code2), 32'd0);
    applyStimulus(10'd1023, -1, -1, '0, lat1, lat2, code1, code2, dac5, dac6, ctrl_high, valids1);
    checkOutput("full_code", 32'(code1), 32'd1023);
    checkOutput("full_code_settle", 32'(code2), 32'd1023);
    applyStimulus(10'd1, -1, -1, '0, lat1, lat2, code1, code2, dac5, dac6, ctrl_high, valids1);
    checkOutput("one_code", 32'(code1), 32'd1);

    applyStimulus(10'd645, -1, -1, '0, lat1, lat2, code1, code2, dac5, dac6, ctrl_high, valids1);
    checkOutput("settle_latency_645", 32'(lat2), 32'd34);
    checkOutput("settle_code_645", 32'(code2), 32'd645);

    applyStimulus(10'd300, -1, 6, 10'd900, lat1, lat2, code1, code2, dac5, dac6, ctrl_high, valids1);
    checkOutput("hold_code", 32'(code1), 32'd300);
    checkOutput("hold_code_settle", 32'(code2), 32'd300);
    checkOutput("hold_ctrl_high", 32'(ctrl_high), 32'd11);
    checkOutput("code_out_kept", 32'(bus1.code_out), 32'd300);

    applyStimulus(10'd200, 8, -1, '0, lat1, lat2, code1, code2, dac5, dac6, ctrl_high, valids1);
    checkOutput("restart_latency", 32'(lat1), 32'd16);
    checkOutput("restart_code", 32'(code1), 32'd200);
    checkOutput("restart_valids", 32'(valids1), 32'd1);
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus1.code_valid || bus2.code_valid) extra++;
    end
    checkOutput("restart_no_extra_valid", 32'(extra), 32'd0);
    checkOutput("restart_busy_low", 32'(bus1.busy) + 32'(bus2.busy), 32'd0);

    // Abort while dut1 is deciding bit 5 (ninth cycle after start).
    vin = 10'd400;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    checkOutput("abort_sh_control", 32'(bus1.sh_control_digital), 32'd0);
    checkOutput("abort_dac_code", 32'(bus1.dac_code), 32'd0);
    checkOutput("abort_busy", 32'(bus1.busy) + 32'(bus2.busy), 32'd0);
    checkOutput("abort_code_out", 32'(bus1.code_out), 32'd0);
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus1.code_valid || bus2.code_valid) extra++;
    end
    checkOutput("abort_no_valid", 32'(extra), 32'd0);

    applyStimulus(10'd77, -1, -1, '0, lat1, lat2, code1, code2, dac5, dac6, ctrl_high, valids1);
    checkOutput("after_abort_code", 32'(code1), 32'd77);
    checkOutput("after_abort_code_settle", 32'(code2), 32'd77);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
